// File: rtl/dbus_interconnect.sv
// dbus_interconnect
//   Data-bus interconnect between the CPU data port and NSLAVES slaves.
//   Addresses decode against ascending slave base addresses (the highest
//   base not above the address wins). Each slave may have a fixed number of
//   wait states; the read and write channels are independent.
//
//   Optional feature, macro DBUS_UNMAPPED_ERR_EN: accesses above TOP_ADDR
//   reach no slave. Instead they raise bus_err for one cycle and record the
//   address in bus_err_addr. Without the macro both of these outputs are
//   tied to 0.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   dread_req/addr              CPU read request and address
//   dread_ready/valid/data      read accept, read data valid, read data
//   dwrite_addr/data/en         CPU write; a nonzero en is a write request
//   dwrite_ready                write channel can accept a request
//   s_dread_addr, s_dread_data  slave read address broadcast and read data
//                               (slot k belongs to slave k)
//   s_dwrite_addr/data/en       slave write broadcast and per-slave strobes
//   bus_err, bus_err_addr       unmapped-access pulse and its sticky address
//
// Read FSM  state | meaning
//   RIDLE | no read outstanding
//   RWAIT | slave wait states counting down, address held
//   RDONE | read data returned this cycle; a new request may be taken
// Write FSM state | meaning
//   WIDLE | ready; zero-wait writes are strobed straight through
//   WWAIT | latched write waiting; strobe when the count reaches 1
module dbus_interconnect #(
  parameter int NSLAVES   = 2,
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 16,
  parameter logic [NSLAVES*ADDRWIDTH-1:0] SLAVE_BASES = {16'h2000, 16'h0000},
  parameter logic [NSLAVES*4-1:0]         WAIT_STATES = {4'd0, 4'd0},
  parameter logic [ADDRWIDTH-1:0]         TOP_ADDR    = 16'hFFFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dread_req,
  input  logic [ADDRWIDTH-1:0]           dread_addr,
  output logic                           dread_ready,
  output logic                           dread_valid,
  output logic [DATAWIDTH-1:0]           dread_data,
  input  logic [ADDRWIDTH-1:0]           dwrite_addr,
  input  logic [DATAWIDTH-1:0]           dwrite_data,
  input  logic [DATAWIDTH/8-1:0]         dwrite_en,
  output logic                           dwrite_ready,
  output logic [ADDRWIDTH-1:0]           s_dread_addr,
  input  logic [NSLAVES*DATAWIDTH-1:0]   s_dread_data,
  output logic [ADDRWIDTH-1:0]           s_dwrite_addr,
  output logic [DATAWIDTH-1:0]           s_dwrite_data,
  output logic [NSLAVES*DATAWIDTH/8-1:0] s_dwrite_en,
  output logic                           bus_err,
  output logic [ADDRWIDTH-1:0]           bus_err_addr
);

  localparam int NB = DATAWIDTH / 8;
  localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic [1:0] {RIDLE, RWAIT, RDONE} rstate_t;
  typedef enum logic       {WIDLE, WWAIT}        wstate_t;

  function automatic logic [SW-1:0] decode(input logic [ADDRWIDTH-1:0] a);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < NSLAVES; k++)
      if (a >= SLAVE_BASES[k*ADDRWIDTH +: ADDRWIDTH]) s = SW'(k);
    return s;
  endfunction

  function automatic logic [3:0] wait_of(input logic [SW-1:0] s);
    logic [3:0] w;
    w = '0;
    for (int k = 0; k < NSLAVES; k++)
      if (s == SW'(k)) w = WAIT_STATES[k*4 +: 4];
    return w;
  endfunction

  // ---------------- read channel ----------------
  rstate_t              rstate, rstate_n;
  logic [3:0]           rcnt, rcnt_n;
  logic [ADDRWIDTH-1:0] raddr, raddr_n;
  logic [SW-1:0]        rsel, rsel_n;
  logic                 rerr, rerr_n;
  logic                 rd_accept, rd_unmapped;
  logic [SW-1:0]        rd_sel;
  logic [3:0]           rd_wait;
  logic [DATAWIDTH-1:0] rd_slot_data;

  assign rd_sel  = decode(dread_addr);
  assign rd_wait = wait_of(rd_sel);

`ifdef DBUS_UNMAPPED_ERR_EN
  assign rd_unmapped = (dread_addr > TOP_ADDR);
`else
  assign rd_unmapped = 1'b0;
`endif

  always_comb begin
    rstate_n  = rstate;
    rcnt_n    = rcnt;
    raddr_n   = raddr;
    rsel_n    = rsel;
    rerr_n    = rerr;
    rd_accept = 1'b0;
    case (rstate)
      RWAIT: begin
        if (rcnt == 4'd1) rstate_n = RDONE;
        else              rcnt_n   = rcnt - 4'd1;
      end
      default: begin
        // RDONE behaves as RIDLE so back-to-back reads stream one per cycle
        rstate_n = RIDLE;
        if (dread_req) begin
          rd_accept = 1'b1;
          raddr_n   = dread_addr;
          rsel_n    = rd_sel;
          rerr_n    = rd_unmapped;
          if (rd_unmapped || rd_wait == 4'd0) begin
            rstate_n = RDONE;
            rcnt_n   = 4'd0;
          end else begin
            rstate_n = RWAIT;
            rcnt_n   = rd_wait;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rstate <= RIDLE;
      rcnt   <= '0;
      raddr  <= '0;
      rsel   <= '0;
      rerr   <= 1'b0;
    end else begin
      rstate <= rstate_n;
      rcnt   <= rcnt_n;
      raddr  <= raddr_n;
      rsel   <= rsel_n;
      rerr   <= rerr_n;
    end
  end

  always_comb begin
    rd_slot_data = '0;
    for (int k = 0; k < NSLAVES; k++)
      if (rsel == SW'(k)) rd_slot_data = s_dread_data[k*DATAWIDTH +: DATAWIDTH];
  end

  assign dread_ready  = (rstate != RWAIT);
  assign dread_valid  = (rstate == RDONE) && !reset;
  assign dread_data   = (dread_valid && !rerr) ? rd_slot_data : '0;
  // synchronous-read slaves need the address stable for the whole wait
  assign s_dread_addr = dread_ready ? dread_addr : raddr;

  // ---------------- write channel ----------------
  wstate_t              wstate, wstate_n;
  logic [3:0]           wcnt, wcnt_n;
  logic [ADDRWIDTH-1:0] waddr, waddr_n;
  logic [DATAWIDTH-1:0] wdata, wdata_n;
  logic [NB-1:0]        wen, wen_n;
  logic [SW-1:0]        wsel, wsel_n;
  logic                 wr_accept, wr_unmapped;
  logic [SW-1:0]        wr_sel, strobe_sel;
  logic [3:0]           wr_wait;
  logic [NB-1:0]        strobe_en;

  assign wr_sel  = decode(dwrite_addr);
  assign wr_wait = wait_of(wr_sel);

`ifdef DBUS_UNMAPPED_ERR_EN
  assign wr_unmapped = (dwrite_addr > TOP_ADDR);
`else
  assign wr_unmapped = 1'b0;
`endif

  always_comb begin
    wstate_n      = wstate;
    wcnt_n        = wcnt;
    waddr_n       = waddr;
    wdata_n       = wdata;
    wen_n         = wen;
    wsel_n        = wsel;
    wr_accept     = 1'b0;
    strobe_en     = '0;
    strobe_sel    = wr_sel;
    s_dwrite_addr = dwrite_addr;
    s_dwrite_data = dwrite_data;
    case (wstate)
      WWAIT: begin
        strobe_sel    = wsel;
        s_dwrite_addr = waddr;
        s_dwrite_data = wdata;
        if (wcnt == 4'd1) begin
          strobe_en = wen;
          wstate_n  = WIDLE;
        end else begin
          wcnt_n = wcnt - 4'd1;
        end
      end
      default: begin
        if (|dwrite_en) begin
          wr_accept = 1'b1;
          if (!wr_unmapped) begin
            if (wr_wait == 4'd0) begin
              strobe_en = dwrite_en;
            end else begin
              wstate_n = WWAIT;
              wcnt_n   = wr_wait;
              waddr_n  = dwrite_addr;
              wdata_n  = dwrite_data;
              wen_n    = dwrite_en;
              wsel_n   = wr_sel;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate <= WIDLE;
      wcnt   <= '0;
      waddr  <= '0;
      wdata  <= '0;
      wen    <= '0;
      wsel   <= '0;
    end else begin
      wstate <= wstate_n;
      wcnt   <= wcnt_n;
      waddr  <= waddr_n;
      wdata  <= wdata_n;
      wen    <= wen_n;
      wsel   <= wsel_n;
    end
  end

  // a write caught by reset in its strobe cycle is dropped, not issued
  always_comb begin
    s_dwrite_en = '0;
    for (int k = 0; k < NSLAVES; k++)
      if (!reset && strobe_sel == SW'(k)) s_dwrite_en[k*NB +: NB] = strobe_en;
  end

  assign dwrite_ready = (wstate == WIDLE);

  // ---------------- unmapped-access reporting ----------------
`ifdef DBUS_UNMAPPED_ERR_EN
  logic rd_err_acc, wr_err_acc;
  assign rd_err_acc = rd_accept && rd_unmapped;
  assign wr_err_acc = wr_accept && wr_unmapped;
  assign bus_err    = !reset && (rd_err_acc || wr_err_acc);

  // read address wins when both channels fault together
  always_ff @(posedge clk) begin
    if (reset)           bus_err_addr <= '0;
    else if (rd_err_acc) bus_err_addr <= dread_addr;
    else if (wr_err_acc) bus_err_addr <= dwrite_addr;
  end
`else
  logic unused_cfg;
  assign unused_cfg   = ^{TOP_ADDR, rd_accept, wr_accept};
  assign bus_err      = 1'b0;
  assign bus_err_addr = '0;
`endif

endmodule

// File: tb/tb_dbus_interconnect.sv
module tb_dbus_interconnect;

  localparam int NS = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NB = DW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              dread_req;
  logic [AW-1:0]     dread_addr;
  logic              dread_ready, dread_valid;
  logic [DW-1:0]     dread_data;
  logic [AW-1:0]     dwrite_addr;
  logic [DW-1:0]     dwrite_data;
  logic [NB-1:0]     dwrite_en;
  logic              dwrite_ready;
  logic [AW-1:0]     s_dread_addr;
  logic [NS*DW-1:0]  s_dread_data;
  logic [AW-1:0]     s_dwrite_addr;
  logic [DW-1:0]     s_dwrite_data;
  logic [NS*NB-1:0]  s_dwrite_en;
  logic              bus_err;
  logic [AW-1:0]     bus_err_addr;

  int total = 0;
  int bad   = 0;

  dbus_interconnect #(
    .NSLAVES(NS), .ADDRWIDTH(AW), .DATAWIDTH(DW),
    .SLAVE_BASES({16'h8000, 16'h2000, 16'h0000}),
    .WAIT_STATES({4'd2, 4'd0, 4'd0}),
    .TOP_ADDR(16'hBFFF)
  ) dut (
    .clk(clk), .reset(reset),
    .dread_req(dread_req), .dread_addr(dread_addr),
    .dread_ready(dread_ready), .dread_valid(dread_valid), .dread_data(dread_data),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
    .dwrite_ready(dwrite_ready),
    .s_dread_addr(s_dread_addr), .s_dread_data(s_dread_data),
    .s_dwrite_addr(s_dwrite_addr), .s_dwrite_data(s_dwrite_data),
    .s_dwrite_en(s_dwrite_en),
    .bus_err(bus_err), .bus_err_addr(bus_err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change on the falling edge; checks land 1 time unit later
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; dread_req = 1'b0; dread_addr = '0;
    dwrite_addr = '0; dwrite_data = '0; dwrite_en = '0;
    // slave0 / slave1 / slave2 read data
    s_dread_data = {16'hBEEF, 16'h1234, 16'h5A5A};
    nxt(); nxt();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(dread_valid), 32'd0);
    chk("rst_data", 32'(dread_data), 32'h0);
    chk("rst_sdwen", 32'(s_dwrite_en), 32'h0);
    chk("rst_buserr", 32'(bus_err), 32'd0);
    chk("rst_buserr_addr", 32'(bus_err_addr), 32'h0);
    chk("rst_rready", 32'(dread_ready), 32'd1);
    chk("rst_wready", 32'(dwrite_ready), 32'd1);

    // zero-wait read from slave1
    nxt(); dread_req = 1'b1; dread_addr = 16'h2004; #1;
    chk("r1_saddr", 32'(s_dread_addr), 32'h2004);
    chk("r1_ready0", 32'(dread_ready), 32'd1);
    nxt(); dread_req = 1'b0; #1;
    chk("r1_valid", 32'(dread_valid), 32'd1);
    chk("r1_data", 32'(dread_data), 32'h1234);
    chk("r1_ready1", 32'(dread_ready), 32'd1);
    nxt(); #1;
    chk("r1_valid_off", 32'(dread_valid), 32'd0);
    chk("r1_data_off", 32'(dread_data), 32'h0);

    // two-wait read from slave2; the CPU address moves but the slave sees 8000
    nxt(); dread_req = 1'b1; dread_addr = 16'h8000; #1;
    chk("r2_ready0", 32'(dread_ready), 32'd1);
    nxt(); dread_req = 1'b0; dread_addr = 16'h0000; #1;
    chk("r2_ready_w1", 32'(dread_ready), 32'd0);
    chk("r2_saddr_w1", 32'(s_dread_addr), 32'h8000);
    chk("r2_valid_w1", 32'(dread_valid), 32'd0);
    nxt(); #1;
    chk("r2_ready_w2", 32'(dread_ready), 32'd0);
    chk("r2_saddr_w2", 32'(s_dread_addr), 32'h8000);
    chk("r2_valid_w2", 32'(dread_valid), 32'd0);
    nxt(); #1;
    chk("r2_valid", 32'(dread_valid), 32'd1);
    chk("r2_data", 32'(dread_data), 32'hBEEF);
    chk("r2_ready3", 32'(dread_ready), 32'd1);

    // boundary: 0x7FFF is the last address of slave1
    nxt(); dread_req = 1'b1; dread_addr = 16'h7FFF; #1;
    nxt(); dread_req = 1'b0; #1;
    chk("r3_data", 32'(dread_data), 32'h1234);

    // zero-wait write to slave0
    nxt(); dwrite_addr = 16'h1FFF; dwrite_data = 16'h00AB; dwrite_en = 2'b01; #1;
    chk("w1_sen", 32'(s_dwrite_en), 32'b000001);
    chk("w1_saddr", 32'(s_dwrite_addr), 32'h1FFF);
    chk("w1_sdata", 32'(s_dwrite_data), 32'h00AB);
    chk("w1_ready", 32'(dwrite_ready), 32'd1);
    nxt(); dwrite_en = 2'b00; #1;
    chk("w1_sen_off", 32'(s_dwrite_en), 32'h0);

    // two-wait write to slave2; a write offered while busy must be ignored
    nxt(); dwrite_addr = 16'h9000; dwrite_data = 16'h5566; dwrite_en = 2'b11; #1;
    chk("w2_sen0", 32'(s_dwrite_en), 32'h0);
    chk("w2_ready0", 32'(dwrite_ready), 32'd1);
    nxt(); dwrite_addr = 16'h0000; dwrite_data = 16'h0000; dwrite_en = 2'b01; #1;
    chk("w2_ready1", 32'(dwrite_ready), 32'd0);
    chk("w2_sen1", 32'(s_dwrite_en), 32'h0);
    nxt(); #1;
    chk("w2_ready2", 32'(dwrite_ready), 32'd0);
    chk("w2_sen2", 32'(s_dwrite_en), 32'b110000);
    chk("w2_saddr2", 32'(s_dwrite_addr), 32'h9000);
    chk("w2_sdata2", 32'(s_dwrite_data), 32'h5566);
    nxt(); dwrite_en = 2'b00; #1;
    chk("w2_ready3", 32'(dwrite_ready), 32'd1);
    chk("w2_sen3", 32'(s_dwrite_en), 32'h0);

    // back-to-back zero-wait reads
    nxt(); dread_req = 1'b1; dread_addr = 16'h0000; #1;
    nxt(); dread_addr = 16'h2000; #1;
    chk("bb_valid0", 32'(dread_valid), 32'd1);
    chk("bb_data0", 32'(dread_data), 32'h5A5A);
    nxt(); dread_addr = 16'h0002; #1;
    chk("bb_valid1", 32'(dread_valid), 32'd1);
    chk("bb_data1", 32'(dread_data), 32'h1234);
    nxt(); dread_req = 1'b0; #1;
    chk("bb_valid2", 32'(dread_valid), 32'd1);
    chk("bb_data2", 32'(dread_data), 32'h5A5A);
    nxt(); #1;
    chk("bb_valid3", 32'(dread_valid), 32'd0);

    // reset in the second wait cycle drops the read
    nxt(); dread_req = 1'b1; dread_addr = 16'h8000; #1;
    nxt(); dread_req = 1'b0; #1;
    nxt(); reset = 1'b1; #1;
    nxt(); reset = 1'b0; #1;
    chk("rr_valid", 32'(dread_valid), 32'd0);
    chk("rr_ready", 32'(dread_ready), 32'd1);
    nxt(); #1;
    chk("rr_valid2", 32'(dread_valid), 32'd0);

    // read above TOP_ADDR
    nxt(); dread_req = 1'b1; dread_addr = 16'hC000; #1;
`ifdef DBUS_UNMAPPED_ERR_EN
    chk("ue_buserr0", 32'(bus_err), 32'd1);
    nxt(); dread_req = 1'b0; #1;
    chk("ue_valid", 32'(dread_valid), 32'd1);
    chk("ue_data", 32'(dread_data), 32'h0);
    chk("ue_buserr1", 32'(bus_err), 32'd0);
    chk("ue_addr", 32'(bus_err_addr), 32'hC000);
    // write above TOP_ADDR: no strobe, error pulse, address captured
    nxt(); dwrite_addr = 16'hD000; dwrite_data = 16'h1111; dwrite_en = 2'b11; #1;
    chk("uw_sen", 32'(s_dwrite_en), 32'h0);
    chk("uw_buserr", 32'(bus_err), 32'd1);
    nxt(); dwrite_en = 2'b00; #1;
    chk("uw_addr", 32'(bus_err_addr), 32'hD000);
    chk("uw_wready", 32'(dwrite_ready), 32'd1);
`else
    chk("ue_buserr0", 32'(bus_err), 32'd0);
    nxt(); dread_req = 1'b0; #1;
    chk("ue_ready_w1", 32'(dread_ready), 32'd0);
    chk("ue_saddr_w1", 32'(s_dread_addr), 32'hC000);
    nxt(); #1;
    chk("ue_ready_w2", 32'(dread_ready), 32'd0);
    nxt(); #1;
    chk("ue_valid", 32'(dread_valid), 32'd1);
    chk("ue_data", 32'(dread_data), 32'hBEEF);
    chk("ue_addr", 32'(bus_err_addr), 32'h0);
`endif

    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_interconnect.md
Name: dbus_interconnect

Overview:
- Parametrised data-bus interconnect between the CPU data port and N slaves (I/O, RAM, peripherals).
- Replaces the fixed two-way memory/IO split in the SoC top level.
- Decodes read and write addresses against ascending slave base addresses.
- Inserts per-slave wait states via ready handshakes and registers the read-return select.

Parameters:
- NSLAVES, 2: number of slave ports, 1..8.
- ADDRWIDTH, 16: address width.
- DATAWIDTH, 16: data width, multiple of 8; byte lanes NB = DATAWIDTH/8.
- SLAVE_BASES, {16'h2000,16'h0000}: packed NSLAVES*ADDRWIDTH; slot k = base of slave k. Slot 0 must be 0; slots strictly ascending.
- WAIT_STATES, {4'd0,4'd0}: packed NSLAVES*4; slot k = extra cycles for slave k, 0..15.
- TOP_ADDR, 16'hFFFF: last mapped address; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dread_req  in  1  CPU read request
- dread_addr  in  ADDRWIDTH  CPU read address
- dread_ready  out  1  read channel can accept a request
- dread_valid  out  1  read data valid
- dread_data  out  DATAWIDTH  read data
- dwrite_addr  in  ADDRWIDTH  CPU write address
- dwrite_data  in  DATAWIDTH  CPU write data
- dwrite_en  in  NB  byte write enables; nonzero = write request
- dwrite_ready  out  1  write channel can accept a request
- s_dread_addr  out  ADDRWIDTH  read address broadcast to all slaves
- s_dread_data  in  NSLAVES*DATAWIDTH  slave read data, slot k = slave k
- s_dwrite_addr  out  ADDRWIDTH  write address broadcast
- s_dwrite_data  out  DATAWIDTH  write data broadcast
- s_dwrite_en  out  NSLAVES*NB  per-slave byte strobes
- bus_err  out  1  one-cycle unmapped-access pulse
- bus_err_addr  out  ADDRWIDTH  last unmapped address (sticky)

Behaviour:
- Decode: sel(a) = highest k with a >= SLAVE_BASES[k]. Pure combinational; no gaps.
- Reset values: dread_valid=0, dread_data=0, s_dwrite_en=0, bus_err=0, bus_err_addr=0, both channels IDLE, dread_ready=1, dwrite_ready=1.
- Read FSM, states RIDLE / RWAIT / RDONE:
  - RIDLE, dread_req=1: latch raddr and rsel = sel(dread_addr); rcnt = WAIT_STATES[rsel]. Go to RDONE if rcnt=0, else RWAIT.
  - RWAIT: decrement rcnt; go to RDONE in the cycle rcnt reaches 1.
  - RDONE: dread_valid=1 and dread_data = s_dread_data[rsel] for exactly one cycle. Accepts a new request in the same cycle (treated as RIDLE): back-to-back zero-wait reads give valid every cycle.
  - dread_ready = (state != RWAIT).
  - s_dread_addr = dread_addr when dread_ready, else raddr (held stable for synchronous-read slaves).
  - Latency: request cycle + 1 + W cycles. dread_data = 0 whenever dread_valid = 0.
- Write FSM, states WIDLE / WWAIT:
  - WIDLE, dwrite_en != 0, W = WAIT_STATES[sel] = 0: s_dwrite_en slot sel = dwrite_en in the same cycle; other slots 0; address/data passed through.
  - W > 0: latch addr/data/en and select; go to WWAIT with wcnt = W; dwrite_ready=0. Strobe the latched slot only in the cycle wcnt reaches 1, then return to WIDLE; dwrite_ready=1 the following cycle.
  - Exactly one strobe cycle per accepted write.
  - dwrite_en ignored while dwrite_ready = 0; the CPU holds it.
- Read and write channels are independent. A simultaneous read and write to the same slave is allowed; the slave resolves ordering.
- Reset mid-operation: the pending read is dropped (no dread_valid); the pending write is dropped (no strobe). Both channels return to IDLE the next cycle.

Optional Feature:
- Macro DBUS_UNMAPPED_ERR_EN.
- Defined:
  - A read with dread_addr > TOP_ADDR completes with zero wait: dread_valid next cycle, dread_data = 0, no slave selected.
  - A write with dwrite_addr > TOP_ADDR produces no strobe.
  - Either case: bus_err pulses one cycle at acceptance and bus_err_addr captures the address. A simultaneous read and write error captures the read address.
- Undefined: no TOP_ADDR check; bus_err and bus_err_addr tied 0.

Test Plan:
Bench configuration: NSLAVES=3, bases 0x0000/0x2000/0x8000, waits 0/0/2, TOP_ADDR=0xBFFF.
- Read 0x2004, slave1 returns 0x1234 -> dread_valid on cycle +1, dread_data=0x1234, dread_ready stays 1.
- Read 0x8000, slave2 returns 0xBEEF -> dread_ready low 2 cycles, s_dread_addr held 0x8000, dread_valid at +3 with 0xBEEF.
- Write 0x1FFF, data 0x00AB, en 2'b01 -> s_dwrite_en slot0=01 same cycle. Then write 0x9000, en 11 -> dwrite_ready low 2 cycles, slot2 strobed once, at +2.
- Reads 0x0000, 0x2000, 0x0002 on consecutive cycles -> three consecutive valid cycles, data from slaves 0, 1, 0.
- Reset asserted in second wait cycle of read 0x8000 -> no dread_valid; dread_ready=1 next cycle.
- With DBUS_UNMAPPED_ERR_EN, read 0xC000 -> dread_data=0, bus_err one pulse, bus_err_addr=0xC000. Without the macro, the same read routes to slave2 with 2 waits.
